// File: rtl/alu_issue_pkg.sv
// Shared constants and the instruction classifier for the ALU issue stage.
package alu_issue_pkg;

    // ALU control codes, as consumed by the ALU's ALUCtrl input.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0111;

    // Major opcodes handled by this stage.
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // funct7 qualifiers.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    // funct3 qualifiers.
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRA = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    // Source of ALU operand 2.
    typedef enum logic [1:0] {
        SRC2_ZERO  = 2'd0,
        SRC2_RS2   = 2'd1,
        SRC2_IMM   = 2'd2,
        SRC2_SHAMT = 2'd3
    } src2_sel_e;

    // Width-independent part of a decoded instruction.
    typedef struct packed {
        logic [3:0] ctrl;
        src2_sel_e  src2;
        logic       illegal;
    } dec_ctl_t;

    // Map opcode/funct fields to an ALU operation and operand-2 source.
    function automatic dec_ctl_t classify(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
        dec_ctl_t c;
        c.ctrl    = ALU_ADD;
        c.src2    = SRC2_ZERO;
        c.illegal = 1'b1;
        if (opcode == OP_R) begin
            c.src2    = SRC2_RS2;
            c.illegal = 1'b0;
            if      (funct7 == F7_BASE && funct3 == F3_ADD) c.ctrl = ALU_ADD;
            else if (funct7 == F7_SUB  && funct3 == F3_ADD) c.ctrl = ALU_SUB;
            else if (funct7 == F7_MUL  && funct3 == F3_ADD) c.ctrl = ALU_MUL;
            else if (funct7 == F7_BASE && funct3 == F3_AND) c.ctrl = ALU_AND;
            else if (funct7 == F7_BASE && funct3 == F3_XOR) c.ctrl = ALU_XOR;
            else if (funct7 == F7_BASE && funct3 == F3_SLL) c.ctrl = ALU_SLL;
            else begin
                c.src2    = SRC2_ZERO;
                c.illegal = 1'b1;
            end
        end else if (opcode == OP_I) begin
            if (funct3 == F3_ADD) begin
                c.ctrl    = ALU_ADD;
                c.src2    = SRC2_IMM;
                c.illegal = 1'b0;
            end else if (funct3 == F3_SRA && funct7 == F7_SRA) begin
                c.ctrl    = ALU_SRA;
                c.src2    = SRC2_SHAMT;
                c.illegal = 1'b0;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder: instruction + register operands -> ALU entry fields.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int width = 32
) (
    input  logic [31:0]      inst_i,
    input  logic [width-1:0] rs1_data_i,
    input  logic [width-1:0] rs2_data_i,
    output logic [3:0]       ctrl_o,
    output logic [width-1:0] data1_o,
    output logic [width-1:0] data2_o,
    output logic [4:0]       rd_o,
    output logic             reg_write_o,
    output logic             illegal_o
);

    dec_ctl_t          ctl;
    logic [width-1:0]  imm_sext;
    logic [width-1:0]  shamt_zext;
    logic [4:0]        rd_field;

    // rs1/rs2 index fields are resolved upstream by the register file.
    logic unused_fields;
    assign unused_fields = ^inst_i[19:15];

    assign ctl        = classify(inst_i[6:0], inst_i[14:12], inst_i[31:25]);
    assign imm_sext   = {{(width-12){inst_i[31]}}, inst_i[31:20]};
    assign shamt_zext = {{(width-5){1'b0}}, inst_i[24:20]};
    assign rd_field   = inst_i[11:7];

    // Operand selection; illegal encodings produce an all-zero entry.
    always_comb begin
        ctrl_o      = ctl.ctrl;
        data1_o     = '0;
        data2_o     = '0;
        rd_o        = '0;
        reg_write_o = 1'b0;
        illegal_o   = ctl.illegal;
        if (!ctl.illegal) begin
            data1_o     = rs1_data_i;
            rd_o        = rd_field;
            reg_write_o = (rd_field != 5'd0);
            case (ctl.src2)
                SRC2_RS2:   data2_o = rs2_data_i;
                SRC2_IMM:   data2_o = imm_sext;
                SRC2_SHAMT: data2_o = shamt_zext;
                default:    data2_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ID/EX issue stage: decoder followed by a single-entry valid/ready register.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      inst_i,
    input  logic [width-1:0] rs1_data_i,
    input  logic [width-1:0] rs2_data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [3:0]       ALUCtrl_o,
    output logic [width-1:0] data1_o,
    output logic [width-1:0] data2_o,
    output logic [4:0]       rd_o,
    output logic             reg_write_o,
    output logic             illegal_o
);

    logic [3:0]       dec_ctrl;
    logic [width-1:0] dec_data1;
    logic [width-1:0] dec_data2;
    logic [4:0]       dec_rd;
    logic             dec_reg_write;
    logic             dec_illegal;

    logic             valid_q, valid_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [width-1:0] data1_q, data1_d;
    logic [width-1:0] data2_q, data2_d;
    logic [4:0]       rd_q, rd_d;
    logic             reg_write_q, reg_write_d;
    logic             illegal_q, illegal_d;

    logic             accept;

    alu_issue_decode #(.width(width)) u_decode (
        .inst_i      (inst_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .ctrl_o      (dec_ctrl),
        .data1_o     (dec_data1),
        .data2_o     (dec_data2),
        .rd_o        (dec_rd),
        .reg_write_o (dec_reg_write),
        .illegal_o   (dec_illegal)
    );

    // The slot is free when empty or when its entry leaves this cycle.
    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    // Next-state: flush beats accept; accept beats drain; otherwise hold.
    always_comb begin
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            ctrl_d      = ALU_ADD;
            data1_d     = '0;
            data2_d     = '0;
            rd_d        = '0;
            reg_write_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            ctrl_d      = dec_ctrl;
            data1_d     = dec_data1;
            data2_d     = dec_data2;
            rd_d        = dec_rd;
            reg_write_d = dec_reg_write;
            illegal_d   = dec_illegal;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            ctrl_q      <= ALU_ADD;
            data1_q     <= '0;
            data2_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
        end
    end

    assign valid_o     = valid_q;
    assign ALUCtrl_o   = ctrl_q;
    assign data1_o     = data1_q;
    assign data2_o     = data2_q;
    assign rd_o        = rd_q;
    assign reg_write_o = reg_write_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios then randomized traffic.
module tb_alu_issue;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_SLL = 4'b0100;
    localparam logic [3:0] C_SRA = 4'b0101;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_MUL = 4'b0111;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_i;
    logic [31:0] inst_i, rs1_data_i, rs2_data_i;
    logic        ready_o, valid_o, reg_write_o, illegal_o;
    logic [3:0]  ALUCtrl_o;
    logic [31:0] data1_o, data2_o;
    logic [4:0]  rd_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    alu_issue #(.width(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .inst_i      (inst_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .ALUCtrl_o   (ALUCtrl_o),
        .data1_o     (data1_o),
        .data2_o     (data2_o),
        .rd_o        (rd_o),
        .reg_write_o (reg_write_o),
        .illegal_o   (illegal_o)
    );

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } ent_t;

    // Reference: what the ALU should see for an instruction, by mnemonic.
    function automatic ent_t ref_decode(logic [31:0] inst, logic [31:0] a, logic [31:0] b);
        ent_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        e  = '{ctrl: C_ADD, d1: 32'd0, d2: 32'd0, rd: 5'd0, rw: 1'b0, ill: 1'b1};
        ok = 1'b1;
        if      (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin e.ctrl = C_ADD; e.d2 = b; end
        else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin e.ctrl = C_SUB; e.d2 = b; end
        else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h01) begin e.ctrl = C_MUL; e.d2 = b; end
        else if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00) begin e.ctrl = C_AND; e.d2 = b; end
        else if (op == 7'h33 && f3 == 3'd4 && f7 == 7'h00) begin e.ctrl = C_XOR; e.d2 = b; end
        else if (op == 7'h33 && f3 == 3'd1 && f7 == 7'h00) begin e.ctrl = C_SLL; e.d2 = b; end
        else if (op == 7'h13 && f3 == 3'd0) begin
            e.ctrl = C_ADD;
            e.d2   = 32'($signed(inst[31:20]));
        end
        else if (op == 7'h13 && f3 == 3'd5 && f7 == 7'h20) begin
            e.ctrl = C_SRA;
            e.d2   = 32'(inst[24:20]);
        end
        else ok = 1'b0;
        if (ok) begin
            e.d1  = a;
            e.rd  = inst[11:7];
            e.rw  = (inst[11:7] != 5'd0);
            e.ill = 1'b0;
        end
        return e;
    endfunction

    // Model of the stage: one held entry plus its valid flag.
    ent_t m_ent;
    logic m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check ready, clock, advance model, check outputs.
    task automatic step(input logic rst, input logic fl, input logic vi,
                        input logic [31:0] inst, input logic [31:0] a,
                        input logic [31:0] b, input logic ri);
        logic m_ready;
        rst_i = rst; flush_i = fl; valid_i = vi; inst_i = inst;
        rs1_data_i = a; rs2_data_i = b; ready_i = ri;
        #2;
        m_ready = !m_valid || ri;
        if (rst) check("ready_o", 32'(ready_o), 32'(m_ready));
        @(posedge clk_i);
        if (!rst) begin
            m_valid = 1'b0;
            m_ent   = '{ctrl: C_ADD, d1: 32'd0, d2: 32'd0, rd: 5'd0, rw: 1'b0, ill: 1'b0};
        end else if (fl) begin
            m_valid = 1'b0;
            m_ent   = '{ctrl: C_ADD, d1: 32'd0, d2: 32'd0, rd: 5'd0, rw: 1'b0, ill: 1'b0};
        end else if (vi && m_ready) begin
            m_valid = 1'b1;
            m_ent   = ref_decode(inst, a, b);
        end else if (m_valid && ri) begin
            m_valid = 1'b0;
        end
        #1;
        check("valid_o",     32'(valid_o),     32'(m_valid));
        check("ALUCtrl_o",   32'(ALUCtrl_o),   32'(m_ent.ctrl));
        check("data1_o",     data1_o,          m_ent.d1);
        check("data2_o",     data2_o,          m_ent.d2);
        check("rd_o",        32'(rd_o),        32'(m_ent.rd));
        check("reg_write_o", 32'(reg_write_o), 32'(m_ent.rw));
        check("illegal_o",   32'(illegal_o),   32'(m_ent.ill));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rd, r1, r2;
        logic [31:0] w;
        rd = 5'($urandom);
        r1 = 5'($urandom);
        r2 = 5'($urandom);
        case ($urandom_range(0, 10))
            0:  w = {7'h00, r2, r1, 3'd0, rd, 7'h33};
            1:  w = {7'h20, r2, r1, 3'd0, rd, 7'h33};
            2:  w = {7'h01, r2, r1, 3'd0, rd, 7'h33};
            3:  w = {7'h00, r2, r1, 3'd7, rd, 7'h33};
            4:  w = {7'h00, r2, r1, 3'd4, rd, 7'h33};
            5:  w = {7'h00, r2, r1, 3'd1, rd, 7'h33};
            6:  w = {12'($urandom), r1, 3'd0, rd, 7'h13};
            7:  w = {7'h20, r2, r1, 3'd5, rd, 7'h13};
            8:  w = {7'($urandom), r2, r1, 3'($urandom), rd, 7'h33};
            9:  w = {7'($urandom), r2, r1, 3'($urandom), rd, 7'h13};
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        m_valid = 1'b0;
        m_ent   = '{ctrl: C_ADD, d1: 32'd0, d2: 32'd0, rd: 5'd0, rw: 1'b0, ill: 1'b0};
        rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        inst_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
        @(posedge clk_i); #1;

        // Reset held for 3 cycles with valid_i asserted.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h402081B3, 32'd10, 32'd3, 1'b1);
            check("rst_valid", 32'(valid_o), 32'd0);
            check("rst_ctrl", 32'(ALUCtrl_o), 32'(C_ADD));
        end
        rst_i = 1'b1; valid_i = 1'b0; #1;
        check("ready_after_rst", 32'(ready_o), 32'd1);

        // sub x3,x1,x2
        step(1'b1, 1'b0, 1'b1, 32'h402081B3, 32'd10, 32'd3, 1'b1);
        check("sub_ctrl", 32'(ALUCtrl_o), 32'(C_SUB));
        check("sub_d1", data1_o, 32'd10);
        check("sub_d2", data2_o, 32'd3);
        check("sub_rd", 32'(rd_o), 32'd3);

        // addi x5,x0,-1 then srai x6,x5,4 back to back
        step(1'b1, 1'b0, 1'b1, 32'hFFF00293, 32'd0, 32'd7, 1'b1);
        check("addi_d2", data2_o, 32'hFFFFFFFF);
        check("addi_ctrl", 32'(ALUCtrl_o), 32'(C_ADD));
        step(1'b1, 1'b0, 1'b1, 32'h4042D313, 32'hFFFFFFFF, 32'd7, 1'b1);
        check("srai_ctrl", 32'(ALUCtrl_o), 32'(C_SRA));
        check("srai_d2", data2_o, 32'd4);
        check("srai_valid", 32'(valid_o), 32'd1);

        // Stall for 4 cycles with a new instruction waiting, then release.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 32'h00A3F433, 32'h1234, 32'h5678, 1'b0);
            check("stall_ctrl", 32'(ALUCtrl_o), 32'(C_SRA));
            check("stall_ready", 32'(ready_o), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1, 32'h00A3F433, 32'h1234, 32'h5678, 1'b1);
        check("post_stall_ctrl", 32'(ALUCtrl_o), 32'(C_AND));

        // Flush while holding an entry and offered a new one.
        step(1'b1, 1'b1, 1'b1, 32'h402081B3, 32'd99, 32'd1, 1'b1);
        check("flush_valid", 32'(valid_o), 32'd0);
        check("flush_rw", 32'(reg_write_o), 32'd0);

        // Illegal encoding and rd=x0.
        step(1'b1, 1'b0, 1'b1, 32'h00000073, 32'd5, 32'd6, 1'b1);
        check("ecall_illegal", 32'(illegal_o), 32'd1);
        check("ecall_rw", 32'(reg_write_o), 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h00208033, 32'd5, 32'd6, 1'b1);
        check("addx0_illegal", 32'(illegal_o), 32'd0);
        check("addx0_rw", 32'(reg_write_o), 32'd0);

        // Drain without a new entry: data holds, valid drops.
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0), rand_inst(), $urandom, $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- ID/EX issue stage. It decodes a 32-bit RV32 instruction word into the 4-bit ALU control code and selects the ALU operands.
- Decoded result is held in a single-entry pipeline register and presented to the ALU with a valid/ready handshake.
- Sits between register-file read and the ALU; it is the producing end of the ALU's ALUCtrl/data1/data2 interface.
- Supports stall (backpressure) and flush.

Parameters:
- width, 32, operand/data width (must match the ALU's width).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- flush_i  in  1  discard held entry and any entry accepted this cycle.
- valid_i  in  1  inst_i/rs1_data_i/rs2_data_i valid.
- ready_o  out  1  stage can accept this cycle.
- inst_i  in  32  instruction word.
- rs1_data_i  in  width  register-file rs1 value.
- rs2_data_i  in  width  register-file rs2 value.
- valid_o  out  1  output entry valid.
- ready_i  in  1  ALU/EX side accepts this cycle.
- ALUCtrl_o  out  4  ALU control code (defs.v encoding).
- data1_o  out  width  ALU operand 1.
- data2_o  out  width  ALU operand 2.
- rd_o  out  5  destination register.
- reg_write_o  out  1  write-back enable.
- illegal_o  out  1  entry is an unsupported instruction.

Behaviour:
- Reset (rst_i==0 at edge):
  - valid_o=0, ALUCtrl_o=`ADD, data1_o=0, data2_o=0, rd_o=0, reg_write_o=0, illegal_o=0.
  - Reset overrides flush and all handshakes.
- Handshake:
  - ready_o = !valid_o || ready_i (combinational; ready_o=1 during reset cycle is don't-care).
  - Accept when valid_i && ready_o: registers load the decoded entry next edge and valid_o=1, giving 1-cycle latency.
  - If valid_o && ready_i && !(valid_i && ready_o): valid_o=0 next edge; data regs hold their last value.
  - valid_o && !ready_i: all outputs hold stable (stall). Inputs are ignored because ready_o=0.
- Flush:
  - flush_i=1 at an edge: valid_o=0 next edge and no accept, regardless of valid_i/ready_i.
  - Data outputs are zeroed: ALUCtrl_o=`ADD, reg_write_o=0, illegal_o=0.
- Decode (opcode=inst[6:0], funct3=inst[14:12], funct7=inst[31:25]):
  - 0110011 / funct7 0000000 / funct3 000 -> `ADD, data2=rs2.
  - 0110011 / 0100000 / 000 -> `SUB, data2=rs2.
  - 0110011 / 0000001 / 000 -> `MUL, data2=rs2.
  - 0110011 / 0000000 / 111 -> `AND, data2=rs2.
  - 0110011 / 0000000 / 100 -> `XOR, data2=rs2.
  - 0110011 / 0000000 / 001 -> `SLL, data2=rs2.
  - 0010011 / funct3 000 -> `ADD (addi), data2 = sign-extend inst[31:20] to width.
  - 0010011 / funct3 101 / funct7 0100000 -> `SRA (srai), data2 = zero-extend inst[24:20].
  - For all legal entries: data1=rs1, rd=inst[11:7], reg_write = (rd != 0), illegal=0.
  - Any other encoding: illegal=1, ALUCtrl=`ADD, data1=data2=0, rd=0, reg_write=0. The entry still flows through the handshake normally.
- Arithmetic/width rules:
  - Immediate sign extension is from bit 31 of inst_i.
  - Shift amount is 5 bits, upper bits zero.
  - No operand modification beyond operand selection.
- Simultaneous events:
  - Accept and drain in the same cycle: the new entry replaces the old one, valid_o stays 1 (full throughput, back-to-back).
  - flush_i with valid_i && ready_i: flush wins.

Decomposition:
- ALU control codes (`ADD, `SUB, `MUL, `AND, `XOR, `SLL, `SRA) and new opcode/funct constants (OP_R=7'b0110011, OP_I=7'b0010011, F7_SUB, F7_MUL, F7_SRA) live in shared defs.v.
- One combinational sub-module, alu_issue_decode: inst + rs1 + rs2 -> ctrl/data1/data2/rd/reg_write/illegal.
- alu_issue wraps the decoder with the pipeline register and handshake.

Test Plan:
- Reset hold: rst_i=0 for 3 cycles with valid_i=1 -> valid_o=0, ALUCtrl_o=`ADD, reg_write_o=0 throughout. Cycle after release, ready_o=1.
- sub x3,x1,x2 (inst 32'h402081B3), rs1=10, rs2=3, ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=`SUB, data1_o=10, data2_o=3, rd_o=3, reg_write_o=1.
- addi x5,x0,-1 (32'hFFF00293), then srai x6,x5,4 (32'h4042D313) back-to-back with ready_i=1:
  - cycle 1: data2_o=32'hFFFFFFFF, `ADD.
  - cycle 2: `SRA, data2_o=4.
  - valid_o continuous.
- Stall: entry held, ready_i=0 for 4 cycles, new valid_i=1 -> ready_o=0, outputs unchanged all 4 cycles. On ready_i=1, the new entry appears the next cycle.
- Flush: valid_o=1 and valid_i=1 with flush_i=1 -> next cycle valid_o=0, reg_write_o=0. The incoming instruction never appears.
- Illegal/rd0: inst 32'h00000073 -> illegal_o=1, reg_write_o=0. add x0,x1,x2 (32'h00208033) -> illegal_o=0, reg_write_o=0.
